// File: rtl/dino_motion.sv
// Vertical motion and leg animation controller for the runner sprite.
// States: RUN = on ground | RISE = jump steps 0-31 | FALL = jump steps 32-63 | DEAD = frozen after collision
module dino_motion #(
    parameter logic [8:0] GROUND_Y = 9'd196,
    parameter int         LEG_DIV  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_jump_req,
    input  logic       i_squat_req,
    input  logic       i_crash,
    input  logic       i_restart,
    output logic [8:0] o_dino_y,
    output logic       o_leg_sel,
    output logic       o_airborne,
    output logic       o_squatting,
    output logic       o_dead
);

    localparam int LEG_CW = (LEG_DIV > 2) ? $clog2(LEG_DIV) : 1;
    localparam logic [LEG_CW-1:0] LEG_LAST = LEG_CW'(LEG_DIV - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t             r_state;
    logic [8:0]         r_dino_y;
    logic [5:0]         r_step;
    logic [LEG_CW-1:0]  r_leg_cnt;
    logic               r_leg_sel;
    logic               r_jump_buf;
    logic               r_squat;

    state_t             w_state_nxt;
    logic [8:0]         w_dino_y_nxt;
    logic [5:0]         w_step_nxt;
    logic [LEG_CW-1:0]  w_leg_cnt_nxt;
    logic               w_leg_sel_nxt;
    logic               w_jump_buf_nxt;
    logic               w_squat_nxt;
    logic [8:0]         w_dy;
    logic               w_buf_eff;

    // Magnitude of the per-tick displacement for the step about to be processed.
    always_comb begin
        w_dy = 9'd6;
        if (r_step < 6'd10)      w_dy = 9'd6;
        else if (r_step < 6'd20) w_dy = 9'd4;
        else if (r_step < 6'd44) w_dy = 9'd2;
        else if (r_step < 6'd54) w_dy = 9'd4;
        else                     w_dy = 9'd6;
    end

    assign w_buf_eff = r_jump_buf | (i_jump_req & (r_step >= 6'd54));

    always_comb begin
        w_state_nxt    = r_state;
        w_dino_y_nxt   = r_dino_y;
        w_step_nxt     = r_step;
        w_leg_cnt_nxt  = r_leg_cnt;
        w_leg_sel_nxt  = r_leg_sel;
        w_jump_buf_nxt = r_jump_buf;

        case (r_state)
            RUN: begin
                if (i_crash) begin
                    w_state_nxt    = DEAD;
                    w_jump_buf_nxt = 1'b0;
                end else if (i_jump_req) begin
                    w_state_nxt = RISE;
                    w_step_nxt  = 6'd0;
                end else if (i_tick) begin
                    if (r_leg_cnt == LEG_LAST) begin
                        w_leg_cnt_nxt = '0;
                        w_leg_sel_nxt = ~r_leg_sel;
                    end else begin
                        w_leg_cnt_nxt = r_leg_cnt + 1'b1;
                    end
                end
            end
            RISE: begin
                if (i_crash) begin
                    w_state_nxt    = DEAD;
                    w_jump_buf_nxt = 1'b0;
                end else if (i_tick) begin
                    w_dino_y_nxt = r_dino_y - w_dy;
                    w_step_nxt   = r_step + 6'd1;
                    if (r_step == 6'd31) w_state_nxt = FALL;
                end
            end
            FALL: begin
                if (i_crash) begin
                    w_state_nxt    = DEAD;
                    w_jump_buf_nxt = 1'b0;
                end else begin
                    w_jump_buf_nxt = w_buf_eff;
                    if (i_tick) begin
                        if (r_step == 6'd63) begin
                            // Landing snaps to ground exactly; a buffered jump relaunches at once.
                            w_dino_y_nxt   = GROUND_Y;
                            w_step_nxt     = 6'd0;
                            w_jump_buf_nxt = 1'b0;
                            w_state_nxt    = w_buf_eff ? RISE : RUN;
                        end else begin
                            w_dino_y_nxt = r_dino_y + w_dy;
                            w_step_nxt   = r_step + 6'd1;
                        end
                    end
                end
            end
            DEAD: begin
                w_jump_buf_nxt = 1'b0;
                if (!i_crash && i_restart) begin
                    w_state_nxt   = RUN;
                    w_dino_y_nxt  = GROUND_Y;
                    w_step_nxt    = 6'd0;
                    w_leg_cnt_nxt = '0;
                    w_leg_sel_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Squat sprite follows the state being entered so a winning jump drops it immediately.
    assign w_squat_nxt = i_squat_req & (w_state_nxt == RUN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_dino_y   <= GROUND_Y;
            r_step     <= 6'd0;
            r_leg_cnt  <= '0;
            r_leg_sel  <= 1'b0;
            r_jump_buf <= 1'b0;
            r_squat    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dino_y   <= w_dino_y_nxt;
            r_step     <= w_step_nxt;
            r_leg_cnt  <= w_leg_cnt_nxt;
            r_leg_sel  <= w_leg_sel_nxt;
            r_jump_buf <= w_jump_buf_nxt;
            r_squat    <= w_squat_nxt;
        end
    end

    assign o_dino_y    = r_dino_y;
    assign o_leg_sel   = r_leg_sel;
    assign o_airborne  = (r_state == RISE) || (r_state == FALL);
    assign o_squatting = r_squat;
    assign o_dead      = (r_state == DEAD);

endmodule

// File: tb/tb_dino_motion.sv
// Bench for dino_motion: jump-height profile model checked every cycle plus literal spot checks.
module tb_dino_motion;

    localparam logic [8:0] G  = 9'd196;
    localparam int         LD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, jump = 1'b0, squat = 1'b0, crash = 1'b0, restart = 1'b0;
    logic [8:0] y;
    logic       leg, air, sq, dead;

    dino_motion #(.GROUND_Y(G), .LEG_DIV(LD)) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_jump_req(jump),
        .i_squat_req(squat), .i_crash(crash), .i_restart(restart),
        .o_dino_y(y), .o_leg_sel(leg), .o_airborne(air),
        .o_squatting(sq), .o_dead(dead)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Height above ground after k ticks of a jump.
    int h[65];
    initial begin
        h[0] = 0;
        for (int k = 0; k < 64; k++)
            h[k+1] = h[k] + (k < 10 ? 6 : k < 20 ? 4 : k < 32 ? 2 : k < 44 ? -2 : k < 54 ? -4 : -6);
    end

    int jk = -1;
    int m_cnt = 0;
    int m_y = 196;
    bit m_dead = 0, m_leg = 0, m_buf = 0, m_sq = 0, m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            jk = -1; m_cnt = 0; m_dead = 0; m_leg = 0; m_buf = 0; m_valid = 1;
        end else if (m_dead) begin
            if (restart && !crash) begin
                m_dead = 0; jk = -1; m_leg = 0; m_cnt = 0; m_buf = 0;
            end
        end else if (crash) begin
            m_dead = 1; m_buf = 0;
        end else if (jk < 0) begin
            if (jump) jk = 0;
            else if (tick) begin
                m_cnt++;
                if (m_cnt == LD) begin m_cnt = 0; m_leg = !m_leg; end
            end
        end else begin
            if (jump && jk >= 54) m_buf = 1;
            if (tick) begin
                jk++;
                if (jk == 64) begin jk = m_buf ? 0 : -1; m_buf = 0; end
            end
        end
        if (!m_dead) m_y = (jk < 0) ? int'(G) : int'(G) - h[jk];
        m_sq = squat && !m_dead && jk < 0;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [8:0] ey;
            logic       eair;
            ey   = m_y[8:0];
            eair = !m_dead && jk >= 0;
            n_tests++;
            if (y !== ey || leg !== m_leg || air !== eair || sq !== m_sq || dead !== m_dead) begin
                n_fail++;
                $display("FAIL model t=%0t y=%0d/%0d leg=%b/%b air=%b/%b sq=%b/%b dead=%b/%b (got/expected)",
                         $time, y, ey, leg, m_leg, air, eair, sq, m_sq, dead, m_dead);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic pulse_jump();
        @(negedge clk) jump = 1'b1;
        @(negedge clk) jump = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_y", int'(y), 196);
        chk("reset_leg", int'(leg), 0);
        chk("reset_air", int'(air), 0);
        chk("reset_dead", int'(dead), 0);
        chk("reset_sq", int'(sq), 0);

        ticks(7);  chk("leg_t7", int'(leg), 0);
        ticks(1);  chk("leg_t8", int'(leg), 1);
        ticks(8);  chk("leg_t16", int'(leg), 0);
        ticks(8);  chk("leg_t24", int'(leg), 1);

        pulse_jump();
        chk("jump_air", int'(air), 1);
        chk("jump_no_move", int'(y), 196);
        ticks(1);  chk("jump_t1", int'(y), 190);
        ticks(9);  chk("jump_t10", int'(y), 136);
        ticks(10); chk("jump_t20", int'(y), 96);
        ticks(12); chk("jump_apex", int'(y), 72);
        chk("jump_leg_hold", int'(leg), 1);
        ticks(12); chk("jump_t44", int'(y), 96);
        ticks(10); chk("jump_t54", int'(y), 136);
        ticks(9);  chk("jump_t63", int'(y), 190);
        chk("jump_t63_air", int'(air), 1);
        ticks(1);  chk("land_y", int'(y), 196);
        chk("land_air", int'(air), 0);

        pulse_jump();
        ticks(56);
        pulse_jump();
        ticks(7);  chk("buf_t63", int'(y), 190);
        ticks(1);  chk("buf_land_y", int'(y), 196);
        chk("buf_land_air", int'(air), 1);
        ticks(1);  chk("buf_relaunch", int'(y), 190);
        ticks(63); chk("buf_done_air", int'(air), 0);

        pulse_jump();
        ticks(40);
        pulse_jump();
        ticks(24);
        chk("early_ignored_air", int'(air), 0);
        chk("early_ignored_y", int'(y), 196);

        pulse_jump();
        ticks(15); chk("rise15_y", int'(y), 116);
        @(negedge clk) crash = 1'b1;
        @(negedge clk);
        chk("crash_dead", int'(dead), 1);
        chk("crash_air", int'(air), 0);
        pulse_restart();
        chk("restart_crash_high", int'(dead), 1);
        crash = 1'b0;
        pulse_jump();
        ticks(100);
        chk("dead_frozen_y", int'(y), 116);
        chk("dead_still", int'(dead), 1);
        pulse_restart();
        chk("restart_dead", int'(dead), 0);
        chk("restart_y", int'(y), 196);
        chk("restart_leg", int'(leg), 0);

        @(negedge clk) squat = 1'b1;
        @(negedge clk);
        chk("squat_on", int'(sq), 1);
        pulse_jump();
        chk("squat_jump_sq", int'(sq), 0);
        chk("squat_jump_air", int'(air), 1);
        ticks(50);
        chk("squat_air_ignored", int'(sq), 0);
        squat = 1'b0;
        chk("pre_rst_y", int'(y), 196 - 124 + 2 * 12 + 4 * 6);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("midrst_y", int'(y), 196);
        chk("midrst_air", int'(air), 0);
        chk("midrst_leg", int'(leg), 0);

        @(negedge clk) begin jump = 1'b1; tick = 1'b1; end
        @(negedge clk) begin jump = 1'b0; tick = 1'b0; end
        chk("coinc_y", int'(y), 196);
        chk("coinc_air", int'(air), 1);
        ticks(1);  chk("coinc_t1", int'(y), 190);
        pulse_restart();
        chk("restart_alive_ignored", int'(y), 190);
        chk("restart_alive_air", int'(air), 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
